// File: rtl/recip_arbiter.sv
// Round-robin arbiter sharing one fixed-latency reciprocal divider between NREQ requesters.
// Grants a request, starts the divider, waits its latency and strobes the result back to the owner.
module recip_arbiter #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned DW          = 16,
    parameter int unsigned RW          = 11,
    parameter int unsigned DIV_LATENCY = 16
) (
    input  logic                 clk48,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   denom_in,
    output logic [NREQ-1:0]      grant,
    output logic                 div_start,
    output logic [DW-1:0]        div_denom,
    input  logic [RW-1:0]        div_recip,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [RW-1:0]        rsp_data,
    output logic                 busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(DIV_LATENCY);
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    state_t            r_state, w_state;
    logic [CW-1:0]     r_cnt, w_cnt;
    logic [PW-1:0]     r_ptr, w_ptr;
    logic [PW-1:0]     r_owner, w_owner;
    logic [NREQ-1:0]   r_grant, w_grant;
    logic              r_div_start, w_div_start;
    logic [DW-1:0]     r_div_denom, w_div_denom;
    logic [NREQ-1:0]   r_rsp_valid, w_rsp_valid;
    logic [RW-1:0]     r_rsp_data, w_rsp_data;
    logic              r_busy, w_busy;

    logic              w_hit;
    logic [PW-1:0]     w_pick;
    logic [PW-1:0]     w_idx;
    logic [DW-1:0]     w_denom_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_denom_arr[g] = denom_in[g*DW +: DW];
    end

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    // First requester at or after the round-robin pointer
    always_comb begin
        w_hit  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = wrap_add(r_ptr, k);
            if (!w_hit && req[w_idx]) begin
                w_hit  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ptr       = r_ptr;
        w_owner     = r_owner;
        w_grant     = '0;
        w_div_start = 1'b0;
        w_div_denom = r_div_denom;
        w_rsp_valid = '0;
        w_rsp_data  = r_rsp_data;
        w_busy      = r_busy;

        case (r_state)
            IDLE, RESP: begin
                w_busy  = 1'b0;
                w_state = IDLE;
                if (w_hit) begin
                    w_state          = RUN;
                    w_grant[w_pick]  = 1'b1;
                    w_busy           = 1'b1;
                    w_owner          = w_pick;
                    w_ptr            = (w_pick == LAST) ? '0 : w_pick + PW'(1);
                    w_cnt            = CW'(DIV_LATENCY - 1);
                    w_div_denom      = w_denom_arr[w_pick];
                    w_div_start      = (w_denom_arr[w_pick] != '0);
                end
            end
            RUN: begin
                // The grant cycle holds the count so the capture lands DIV_LATENCY cycles after div_start
                if (r_grant != '0) begin
                    w_cnt = r_cnt;
                end else if (r_cnt == '0) begin
                    w_state              = RESP;
                    w_busy               = 1'b0;
                    w_rsp_valid[r_owner] = 1'b1;
                    w_rsp_data           = (r_div_denom == '0) ? '1 : div_recip;
                end else begin
                    w_cnt = r_cnt - CW'(1);
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_grant     <= '0;
            r_div_start <= 1'b0;
            r_div_denom <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ptr       <= w_ptr;
            r_owner     <= w_owner;
            r_grant     <= w_grant;
            r_div_start <= w_div_start;
            r_div_denom <= w_div_denom;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_data  <= w_rsp_data;
            r_busy      <= w_busy;
        end
    end

    assign grant     = r_grant;
    assign div_start = r_div_start;
    assign div_denom = r_div_denom;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;

endmodule

// File: tb/tb_recip_arbiter.sv
// Directed bench for recip_arbiter: operation table plus fairness, late-arrival and reset sequences.
module tb_recip_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned RW   = 11;
    localparam int unsigned LAT  = 16;

    logic              clk48 = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] denom_in;
    logic [NREQ-1:0]   grant;
    logic              div_start;
    logic [DW-1:0]     div_denom;
    logic [RW-1:0]     div_recip;
    logic [NREQ-1:0]   rsp_valid;
    logic [RW-1:0]     rsp_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    recip_arbiter #(
        .NREQ(NREQ),
        .DW(DW),
        .RW(RW),
        .DIV_LATENCY(LAT)
    ) dut (
        .clk48(clk48),
        .rst(rst),
        .req(req),
        .denom_in(denom_in),
        .grant(grant),
        .div_start(div_start),
        .div_denom(div_denom),
        .div_recip(div_recip),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .busy(busy)
    );

    always #5 clk48 = ~clk48;

    // Divider model: 65536/d saturated to 11 bits, valid only LAT cycles after div_start
    function automatic logic [RW-1:0] recip_model(input logic [DW-1:0] d);
        int unsigned q;
        if (d == '0) return '1;
        q = 65536 / 32'(d);
        return (q > 2047) ? 11'h7FF : RW'(q);
    endfunction

    int unsigned   m_cnt = 0;
    logic [DW-1:0] m_d   = '0;
    always @(posedge clk48) begin
        if (div_start) begin
            m_cnt <= 1;
            m_d   <= div_denom;
        end else if (m_cnt != 0 && m_cnt < 40) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign div_recip = (m_cnt == LAT) ? recip_model(m_d) : 11'h2AA;

    task automatic tick();
        @(negedge clk48);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  exp_grant;
        logic        exp_start;
        logic [15:0] exp_denom;
        logic [10:0] exp_data;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, starts, busy_cnt, cyc, ng, nr, both, extra;
        int g_cyc [8];
        int r_cyc [8];
        logic [1:0]  g_vec [8];
        logic [1:0]  r_vec [8];
        logic [10:0] r_dat [8];
        logic [1:0]  exp_v;

        // Round-robin pointer evolves across rows: 0 ->1 ->0 ->1 ->0 ->1 ->1 ->0
        vecs[0] = '{2'b01, 16'h0021, 16'h0000, 2'b01, 1'b1, 16'h0021, 11'h7C1};
        vecs[1] = '{2'b10, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'h0000, 11'h7FF};
        vecs[2] = '{2'b11, 16'h0100, 16'h0040, 2'b01, 1'b1, 16'h0100, 11'h100};
        vecs[3] = '{2'b11, 16'h0100, 16'h0040, 2'b10, 1'b1, 16'h0040, 11'h400};
        vecs[4] = '{2'b01, 16'hFFFF, 16'h0040, 2'b01, 1'b1, 16'hFFFF, 11'h001};
        vecs[5] = '{2'b01, 16'h8000, 16'h0040, 2'b01, 1'b1, 16'h8000, 11'h002};
        vecs[6] = '{2'b10, 16'h8000, 16'h0000, 2'b10, 1'b0, 16'h0000, 11'h7FF};

        rst = 1'b1;
        req = '0;
        denom_in = '0;
        repeat (2) tick();
        check("rst_grant", 32'(grant), 0);
        check("rst_div_start", 32'(div_start), 0);
        check("rst_div_denom", 32'(div_denom), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            req = vecs[i].req;
            denom_in = {vecs[i].d1, vecs[i].d0};
            tick();
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d_div_start", i), 32'(div_start), 32'(vecs[i].exp_start));
            check($sformatf("v%0d_div_denom", i), 32'(div_denom), 32'(vecs[i].exp_denom));
            check($sformatf("v%0d_busy", i), 32'(busy), 1);
            req = '0;
            lat = 0;
            starts = 0;
            busy_cnt = 0;
            do begin
                tick();
                lat++;
                if (div_start) starts++;
                if (busy) busy_cnt++;
            end while (rsp_valid == '0 && lat < 40);
            check($sformatf("v%0d_rsp_latency", i), 32'(lat), 17);
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d_rsp_data", i), 32'(rsp_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_extra_starts", i), 32'(starts), 0);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt), 16);
            tick();
            check($sformatf("v%0d_quiet", i), {28'd0, grant, rsp_valid}, 0);
            check($sformatf("v%0d_rsp_hold", i), 32'(rsp_data), 32'(vecs[i].exp_data));
        end

        // Fairness and back-to-back spacing with both requests held from reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        req = 2'b11;
        denom_in = {16'h0040, 16'h0100};
        ng = 0; nr = 0; cyc = 0; both = 0;
        for (int k = 0; k < 8; k++) begin
            g_cyc[k] = 0; r_cyc[k] = 0; g_vec[k] = '0; r_vec[k] = '0; r_dat[k] = '0;
        end
        while (nr < 6 && cyc < 150) begin
            tick();
            cyc++;
            if (grant != '0 && rsp_valid != '0) both++;
            if (grant != '0 && ng < 8) begin
                g_cyc[ng] = cyc; g_vec[ng] = grant; ng++;
            end
            if (rsp_valid != '0 && nr < 8) begin
                r_cyc[nr] = cyc; r_vec[nr] = rsp_valid; r_dat[nr] = rsp_data; nr++;
            end
        end
        req = '0;
        check("fair_num_grants", 32'(ng), 6);
        check("fair_num_rsps", 32'(nr), 6);
        check("fair_overlap", 32'(both), 0);
        check("fair_first_grant_cycle", 32'(g_cyc[0]), 1);
        for (int k = 0; k < 6; k++) begin
            exp_v = (k % 2 == 1) ? 2'b10 : 2'b01;
            check($sformatf("fair%0d_grant", k), 32'(g_vec[k]), 32'(exp_v));
            check($sformatf("fair%0d_rsp_valid", k), 32'(r_vec[k]), 32'(exp_v));
            check($sformatf("fair%0d_latency", k), 32'(r_cyc[k] - g_cyc[k]), 17);
            check($sformatf("fair%0d_data", k), 32'(r_dat[k]), (k % 2 == 1) ? 32'h400 : 32'h100);
            if (k > 0) check($sformatf("fair%0d_spacing", k), 32'(g_cyc[k] - g_cyc[k-1]), 18);
        end
        tick();
        check("fair_idle_after", {29'd0, busy, grant}, 0);

        // Late arrival of requester 1 while requester 0 runs
        req = 2'b01;
        denom_in = {16'h0040, 16'h0100};
        tick();
        check("late_grant0", 32'(grant), 32'b01);
        req = '0;
        repeat (5) tick();
        req = 2'b10;
        lat = 5;
        extra = 0;
        do begin
            tick();
            lat++;
            if (grant != '0) extra++;
        end while (rsp_valid == '0 && lat < 40);
        check("late_rsp0_latency", 32'(lat), 17);
        check("late_rsp0_valid", 32'(rsp_valid), 32'b01);
        check("late_no_early_grant", 32'(extra), 0);
        tick();
        check("late_grant1", 32'(grant), 32'b10);
        req = '0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (rsp_valid == '0 && lat < 40);
        check("late_rsp1_latency", 32'(lat), 17);
        check("late_rsp1_data", {21'd0, rsp_valid, rsp_data}, {21'd0, 2'b10, 11'h400});

        // Reset five cycles into an operation; pointer would otherwise favour requester 1
        tick();
        req = 2'b01;
        tick();
        check("rstmid_grant0", 32'(grant), 32'b01);
        req = '0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_busy", 32'(busy), 0);
        check("rstmid_div_denom", 32'(div_denom), 0);
        extra = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (rsp_valid != '0 || busy) extra++;
        end
        check("rstmid_no_rsp", 32'(extra), 0);
        req = 2'b11;
        tick();
        check("rstmid_regrant", 32'(grant), 32'b01);
        req = '0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (rsp_valid == '0 && lat < 40);
        check("rstmid_rsp", {16'd0, lat[4:0], rsp_data}, {16'd0, 5'd17, 11'h100});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/recip_arbiter.md
Name: recip_arbiter

Overview:
Time-shares one iterative reciprocal unit (the recip16 divider) between up to NREQ requesters. Typical requesters are the perspective-plane per-line step and the scroller/raster-effect scaling.
The block takes requests with a req/grant handshake, picks a winner by round-robin, and issues the divider start pulse and denominator. It waits the divider's fixed latency, then returns the result to the winner with a one-cycle response strobe.
It sits between the per-line effect logic and the single divider instance in the VGA demo, all in the pixel-clock domain.

Parameters:
NREQ, 2, number of requesters (2..4)
DW, 16, denominator width in bits
RW, 11, reciprocal result width in bits
DIV_LATENCY, 16, cycles from div_start high to div_recip valid (fixed, ≥2)

Ports:
clk48  in  1  pixel clock; only clock in the block
rst  in  1  synchronous reset, active-high
req  in  NREQ  per-requester request level; hold until granted
denom_in  in  NREQ*DW  packed denominators; slice i belongs to req[i]; stable while req[i] high
grant  out  NREQ  one-hot, one-cycle pulse: request accepted
div_start  out  1  one-cycle start pulse to divider
div_denom  out  DW  denominator to divider; held from grant until result captured
div_recip  in  RW  divider result; valid DIV_LATENCY cycles after div_start
rsp_valid  out  NREQ  one-hot, one-cycle: result for that requester on rsp_data
rsp_data  out  RW  result; holds its last value between strobes
busy  out  1  high from grant cycle through the cycle before the state returns to IDLE

Behaviour:
- All outputs are registered.
- Reset values: grant=0, div_start=0, div_denom=0, rsp_valid=0, rsp_data=0, busy=0, state=IDLE, cnt=0, rr pointer=0 (requester 0 has top priority), owner=0.
- States: IDLE, RUN, RESP.
- IDLE:
  - If any req is sampled high at edge N, choose the first set req[i] scanning i = ptr, ptr+1, ... mod NREQ.
  - During cycle N+1: grant[i]=1, busy=1, div_denom=denom_in[i], owner=i, ptr=(i+1) mod NREQ, state=RUN, cnt=DIV_LATENCY-1.
  - div_start=1 in the same cycle, unless the denominator is zero (see zero rule).
- RUN:
  - cnt decrements each cycle.
  - When cnt==0, capture div_recip into rsp_data and go to RESP. This capture is at the edge ending cycle S+DIV_LATENCY, where S is the grant cycle.
- RESP (cycle S+DIV_LATENCY+1):
  - rsp_valid[owner]=1 and busy=0.
  - req is sampled this cycle as in IDLE, so a new grant can appear at S+DIV_LATENCY+2.
  - Back-to-back throughput: one operation per DIV_LATENCY+2 cycles.
- Requests arriving or held during RUN/RESP are neither granted nor lost; they are arbitrated at the next sampling point.
- Requester contract:
  - Drop req in the grant cycle or the one after; req still high one cycle after grant counts as a new request.
  - denom_in is not sampled after grant.
- Zero denominator:
  - If the chosen denominator is 0, div_start stays 0 and the divider is untouched.
  - rsp_data is forced to all-ones (2^RW-1).
  - Timing and rsp_valid are identical to a normal operation, so consumers see a constant latency.
- Only one grant and at most one rsp_valid bit are ever high in a cycle. grant and rsp_valid never assert in the same cycle.
- Reset mid-operation:
  - Any in-flight result is discarded; no rsp_valid is issued.
  - All state returns to reset values, and the next request goes through normal arbitration from ptr=0.
- ptr wraps modulo NREQ. For non-power-of-two NREQ, explicitly wrap NREQ-1 → 0.

Test Plan:
1. Single op, DIV_LATENCY=16: req[0]=1 with denom 0x0021 sampled at edge 10 → cycle 11: grant=01, div_start=1, div_denom=0x0021, busy=1. Cycle 28: rsp_valid=01, rsp_data = divider model value for 0x0021. Cycle 29: no strobes.
2. Simultaneous request after reset: req=11 sampled at edge 10 → grant[0] at cycle 11, rsp_valid[0] at cycle 28. Then grant[1] at cycle 29, rsp_valid[1] at cycle 46. Spacing is 18 cycles.
3. Fairness: both req held continuously for 6 operations → grant order 0,1,0,1,0,1. rsp_valid always goes to the bit granted 17 cycles earlier.
4. Zero denominator: req[1] with denom 0 → grant[1], div_start stays 0 for the whole operation. rsp_valid[1] arrives 17 cycles after grant with rsp_data=0x7FF.
5. Late arrival: req[1] rises during RUN of req[0] → no grant until the RESP cycle sample. grant[1] appears one cycle after rsp_valid[0], and the request is not dropped.
6. Reset mid-RUN: rst=1 for one cycle 5 cycles after grant[0] → busy=0, no rsp_valid ever issued for that operation. The next req=11 grants requester 0 first.
